multi_cycle_ctrl: RTL
=====================

MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 Parameter CNT_W, default 32, width of the retired-instruction counter.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 op  input  6  opcode field of the instruction register (instr[31:26]).
REQ-005 funct  input  6  function field of the instruction register (instr[5:0]).
REQ-006 zero  input  1  ALU Zero flag, valid in EXEC.
REQ-007 mem_ready  input  1  memory handshake; access completes in the cycle where it is high.
REQ-008 im_rd  output  1  instruction-read request.
REQ-009 ir_wr  output  1  instruction-register load strobe.
REQ-010 pc_wr  output  1  PC load strobe.
REQ-011 rf_wr  output  1  register-file write strobe.
REQ-012 dm_rd  output  1  data-memory read request.
REQ-013 dm_wr  output  1  data-memory write request.
REQ-014 state  output  3  current FSM state code.
REQ-015 illegal  output  1  one-cycle pulse for an unsupported opcode.
REQ-016 retired  output  CNT_W  count of completed instructions.

Function
REQ-017 The block SHALL have state codes FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; codes 5-7 SHALL go to FETCH on the next edge with all strobes 0.
REQ-018 Supported classes: R-ALU (op 0x00, funct not 0x08), JR (op 0x00, funct 0x08), I-ALU (op 0x08-0x0F), LW 0x23, SW 0x2B, BEQ 0x04, BNE 0x05, J 0x02, JAL 0x03.
REQ-019 FETCH SHALL assert im_rd; FETCH SHALL hold while mem_ready=0; with mem_ready=1 it SHALL assert ir_wr and pc_wr (PC+4) and go to DECODE.
REQ-020 DECODE for J/JR SHALL assert pc_wr, retire and go to FETCH (2 cycles total at zero wait).
REQ-021 DECODE for JAL SHALL assert pc_wr and rf_wr (link to $31), retire and go to FETCH.
REQ-022 DECODE for an unsupported op SHALL pulse illegal, write nothing, not retire, and go to FETCH.
REQ-023 DECODE for any other supported class SHALL go to EXEC with no strobes.
REQ-024 EXEC for BEQ SHALL assert pc_wr iff zero=1; for BNE iff zero=0; either way it retires and goes to FETCH.
REQ-025 EXEC for LW/SW SHALL go to MEM; for R-ALU/I-ALU it SHALL go to WB.
REQ-026 MEM SHALL assert dm_rd (LW) or dm_wr (SW) while waiting and SHALL hold until mem_ready=1.
REQ-027 On MEM completion, SW SHALL retire and go to FETCH; LW SHALL go to WB.
REQ-028 WB SHALL assert rf_wr for exactly one cycle, retire and go to FETCH.
REQ-029 Strobes SHALL be combinational (Moore plus the mem_ready/zero/op qualifiers above); at most one of rf_wr, dm_wr SHALL be high in any cycle.
REQ-030 retired SHALL increment by 1 on each retiring edge and wrap from 2^CNT_W-1 to 0.
REQ-031 op and funct SHALL be sampled only in DECODE, EXEC, MEM and WB; changes on them during FETCH SHALL be ignored.

Reset
REQ-032 On a clock edge with rst=1, state SHALL become FETCH, retired SHALL become 0 and illegal SHALL become 0.
REQ-033 While rst=1, every strobe output SHALL be 0 in the same cycle, including mid-MEM (no dm_wr escapes) and mid-WB.
REQ-034 After rst falls, FETCH SHALL begin on the next cycle without any spurious pc_wr.

Structure
REQ-035 The state codes and the opcode/funct constants SHALL live in the shared encoding package/include, alongside the existing ALU and NPC encodings.
REQ-036 Instruction classification SHALL be a combinational sub-module, mc_decode, that maps op/funct to a one-hot class; the FSM and the counter SHALL stay in multi_cycle_ctrl.

Verification
REQ-037 ADD (op 0x00, funct 0x20), mem_ready=1 -> states 0,1,2,4,0; rf_wr is high only in WB; retired goes 0->1.
REQ-038 LW with mem_ready low for 2 cycles in both FETCH and MEM -> 9 cycles total; dm_rd is held for 3 cycles; rf_wr fires once.
REQ-039 BEQ with zero=1, then BNE with zero=1 -> pc_wr pulses in EXEC for the first and not the second; retired advances by 2.
REQ-040 JAL, then op 0x3F -> the first is a 2-cycle JAL with pc_wr and rf_wr both in DECODE; the second pulses illegal with no strobes, and retired advances by 1.
REQ-041 SW with rst asserted during MEM wait -> dm_wr drops in the rst cycle, state is 0 next, retired is 0.
REQ-042 Preload retired to all-ones via 2^32-1 J instructions (or a bench force), then one J -> retired reads 0.

Source files
------------

// File: rtl/multi_cycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle controller: FSM state codes, opcode and
// funct constants, instruction-class payload, and the ALU / next-PC encodings
// used by the surrounding datapath.
package multi_cycle_ctrl_pkg;

    localparam int unsigned OP_W    = 6;
    localparam int unsigned FUNCT_W = 6;
    localparam int unsigned STATE_W = 3;

    // FSM state codes; 5..7 are unused and recover to FETCH
    typedef enum logic [STATE_W-1:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    // Opcode field values (instr[31:26])
    localparam logic [OP_W-1:0] OP_RTYPE   = 6'h00;
    localparam logic [OP_W-1:0] OP_J       = 6'h02;
    localparam logic [OP_W-1:0] OP_JAL     = 6'h03;
    localparam logic [OP_W-1:0] OP_BEQ     = 6'h04;
    localparam logic [OP_W-1:0] OP_BNE     = 6'h05;
    localparam logic [OP_W-1:0] OP_IALU_LO = 6'h08;
    localparam logic [OP_W-1:0] OP_IALU_HI = 6'h0F;
    localparam logic [OP_W-1:0] OP_LW      = 6'h23;
    localparam logic [OP_W-1:0] OP_SW      = 6'h2B;

    // Function field values (instr[5:0]) for R-type
    localparam logic [FUNCT_W-1:0] FUNCT_JR = 6'h08;

    // One-hot instruction class; all-zero means unsupported opcode
    typedef struct packed {
        logic r_alu;
        logic jr;
        logic i_alu;
        logic lw;
        logic sw;
        logic beq;
        logic bne;
        logic j;
        logic jal;
    } cls_t;

    // ALU operation encoding used by the datapath
    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_NOR = 4'd5,
        ALU_SLT = 4'd6,
        ALU_LUI = 4'd7
    } alu_op_t;

    // Next-PC source encoding used by the datapath
    typedef enum logic [1:0] {
        NPC_PC4    = 2'd0,
        NPC_BRANCH = 2'd1,
        NPC_JUMP   = 2'd2,
        NPC_REG    = 2'd3
    } npc_sel_t;

endpackage

// File: rtl/multi_cycle_ctrl_if.sv
// Controller <-> datapath bundle.
//   op, funct, zero, mem_ready : datapath -> controller
//   im_rd, ir_wr, pc_wr, rf_wr, dm_rd, dm_wr, illegal : controller strobes
//   state, retired : controller status
// master = datapath side, slave = controller side.
interface multi_cycle_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    import multi_cycle_ctrl_pkg::*;

    logic [OP_W-1:0]    op;
    logic [FUNCT_W-1:0] funct;
    logic               zero;
    logic               mem_ready;

    logic               im_rd;
    logic               ir_wr;
    logic               pc_wr;
    logic               rf_wr;
    logic               dm_rd;
    logic               dm_wr;
    logic [STATE_W-1:0] state;
    logic               illegal;
    logic [CNT_W-1:0]   retired;

    modport master (
        output op, funct, zero, mem_ready,
        input  im_rd, ir_wr, pc_wr, rf_wr, dm_rd, dm_wr, state, illegal, retired
    );

    modport slave (
        input  op, funct, zero, mem_ready,
        output im_rd, ir_wr, pc_wr, rf_wr, dm_rd, dm_wr, state, illegal, retired
    );

endinterface

// File: rtl/mc_decode.sv
// Combinational instruction classifier.
//   op    : opcode field
//   funct : function field (only meaningful for op 0x00)
//   cls   : one-hot instruction class, all-zero for unsupported opcodes
module mc_decode
    import multi_cycle_ctrl_pkg::*;
(
    input  logic [OP_W-1:0]    op,
    input  logic [FUNCT_W-1:0] funct,
    output cls_t               cls
);

    // Map opcode (and funct for R-type) onto a single class bit
    always_comb begin
        cls = '0;
        if (op == OP_RTYPE) begin
            if (funct == FUNCT_JR) cls.jr    = 1'b1;
            else                   cls.r_alu = 1'b1;
        end else if (op >= OP_IALU_LO && op <= OP_IALU_HI) begin
            cls.i_alu = 1'b1;
        end else begin
            case (op)
                OP_LW:   cls.lw  = 1'b1;
                OP_SW:   cls.sw  = 1'b1;
                OP_BEQ:  cls.beq = 1'b1;
                OP_BNE:  cls.bne = 1'b1;
                OP_J:    cls.j   = 1'b1;
                OP_JAL:  cls.jal = 1'b1;
                default: cls     = '0;
            endcase
        end
    end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle CPU control FSM with retired-instruction counter.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of multi_cycle_ctrl_if (op/funct/zero/mem_ready in;
//              combinational strobes, state code, illegal pulse and
//              retired count out)
// Strobes are decoded from the current state plus op/funct/zero/mem_ready and
// are forced low while rst is high.
module multi_cycle_ctrl
    import multi_cycle_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    multi_cycle_ctrl_if.slave bus
);

    state_t           state_q;
    state_t           state_d;
    cls_t             cls;
    logic             is_illegal;
    logic             retire_c;
    logic [CNT_W-1:0] retired_q;

    logic im_rd_c, ir_wr_c, pc_wr_c, rf_wr_c, dm_rd_c, dm_wr_c, illegal_c;

    // op/funct only influence behaviour outside FETCH; FETCH never looks at cls
    mc_decode u_decode (
        .op    (bus.op),
        .funct (bus.funct),
        .cls   (cls)
    );

    assign is_illegal = ~|cls;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (bus.mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                if (cls.j || cls.jr || cls.jal || is_illegal) state_d = S_FETCH;
                else                                          state_d = S_EXEC;
            end
            S_EXEC: begin
                if (cls.lw || cls.sw)             state_d = S_MEM;
                else if (cls.r_alu || cls.i_alu)  state_d = S_WB;
                else                              state_d = S_FETCH;
            end
            S_MEM: begin
                // A non-memory op here can only come from a corrupted IR; recover
                if (!(cls.lw || cls.sw))  state_d = S_FETCH;
                else if (bus.mem_ready)   state_d = cls.lw ? S_WB : S_FETCH;
            end
            S_WB:    state_d = S_FETCH;
            default: state_d = S_FETCH;
        endcase
    end

    // Output decode; everything held low during reset
    always_comb begin
        im_rd_c   = 1'b0;
        ir_wr_c   = 1'b0;
        pc_wr_c   = 1'b0;
        rf_wr_c   = 1'b0;
        dm_rd_c   = 1'b0;
        dm_wr_c   = 1'b0;
        illegal_c = 1'b0;
        retire_c  = 1'b0;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    im_rd_c = 1'b1;
                    ir_wr_c = bus.mem_ready;
                    pc_wr_c = bus.mem_ready;
                end
                S_DECODE: begin
                    if (cls.j || cls.jr) begin
                        pc_wr_c  = 1'b1;
                        retire_c = 1'b1;
                    end else if (cls.jal) begin
                        pc_wr_c  = 1'b1;
                        rf_wr_c  = 1'b1;
                        retire_c = 1'b1;
                    end else if (is_illegal) begin
                        illegal_c = 1'b1;
                    end
                end
                S_EXEC: begin
                    if (cls.beq) begin
                        pc_wr_c  = bus.zero;
                        retire_c = 1'b1;
                    end else if (cls.bne) begin
                        pc_wr_c  = ~bus.zero;
                        retire_c = 1'b1;
                    end
                end
                S_MEM: begin
                    dm_rd_c  = cls.lw;
                    dm_wr_c  = cls.sw;
                    retire_c = cls.sw & bus.mem_ready;
                end
                S_WB: begin
                    rf_wr_c  = 1'b1;
                    retire_c = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Retired-instruction counter, wraps naturally at 2^CNT_W
    always_ff @(posedge clk) begin
        if (rst)           retired_q <= '0;
        else if (retire_c) retired_q <= retired_q + CNT_W'(1);
    end

    assign bus.im_rd   = im_rd_c;
    assign bus.ir_wr   = ir_wr_c;
    assign bus.pc_wr   = pc_wr_c;
    assign bus.rf_wr   = rf_wr_c;
    assign bus.dm_rd   = dm_rd_c;
    assign bus.dm_wr   = dm_wr_c;
    assign bus.illegal = illegal_c;
    assign bus.state   = STATE_W'(state_q);
    assign bus.retired = retired_q;

endmodule
